// File: rtl/bcd_sweep_ctrl.sv
// Sequencing controller for a two-digit BCD up/down counter: button conditioning,
// tick prescaler, direction FSM (up / down / paused) and terminal-count wrap signalling.
module bcd_sweep_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_mode,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  output logic       cnt_en,
  output logic       ud,
  output logic       pause,
  output logic [1:0] mode,
  output logic       wrap
);

  localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] M_UP    = 2'b00;
  localparam logic [1:0] M_DOWN  = 2'b01;
  localparam logic [1:0] M_SWEEP = 2'b10;

  typedef enum logic [1:0] {
    S_RUN_UP   = 2'd0,
    S_RUN_DOWN = 2'd1,
    S_PAUSED   = 2'd2
  } state_t;

  // Button vectors: bit 0 = pause, bit 1 = mode.
  logic [1:0]    w_btn;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_lvl;
  logic [1:0]    r_lvl_d;
  logic [1:0]    r_press;
  logic [DW-1:0] r_db_cnt [2];

  state_t        r_state;
  logic          r_saved_up;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_mode;
  logic          r_ud;
  logic          r_pause;
  logic          r_wrap;

  state_t        w_state_nxt;
  logic [1:0]    w_mode_nxt;
  logic          w_saved_nxt;
  logic          w_rev;
  logic          w_cnt_en;
  logic          w_fb99;
  logic          w_fb00;
  logic          w_wrap_single;

  assign w_btn = {btn_mode, btn_pause};

  // Level flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      r_press <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      r_press <= r_lvl & ~r_lvl_d;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_lvl[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_MAX) begin
          r_lvl[b]    <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_fb99        = (ten == 4'd9) && (one == 4'd9);
  assign w_fb00        = (ten == 4'd0) && (one == 4'd0);
  assign w_cnt_en      = (r_presc == PRESC_MAX) && (r_state != S_PAUSED);
  assign w_wrap_single = w_cnt_en && (((r_mode == M_UP) && w_fb99) ||
                                      ((r_mode == M_DOWN) && w_fb00));

  // Mode press resolves first, then pause, then the sweep reversal on the result.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_state_nxt = r_state;
    w_saved_nxt = r_saved_up;
    w_rev       = 1'b0;

    if (r_press[1]) begin
      case (r_mode)
        M_SWEEP: w_mode_nxt = M_UP;
        M_UP:    w_mode_nxt = M_DOWN;
        default: w_mode_nxt = M_SWEEP;
      endcase
      if (r_state != S_PAUSED) begin
        if (w_mode_nxt == M_UP)        w_state_nxt = S_RUN_UP;
        else if (w_mode_nxt == M_DOWN) w_state_nxt = S_RUN_DOWN;
      end
    end

    if (r_press[0]) begin
      if (w_state_nxt == S_PAUSED) begin
        case (w_mode_nxt)
          M_UP:    w_state_nxt = S_RUN_UP;
          M_DOWN:  w_state_nxt = S_RUN_DOWN;
          default: w_state_nxt = r_saved_up ? S_RUN_UP : S_RUN_DOWN;
        endcase
      end else begin
        w_saved_nxt = (w_state_nxt == S_RUN_UP);
        w_state_nxt = S_PAUSED;
      end
    end

    if ((w_mode_nxt == M_SWEEP) && !w_cnt_en) begin
      if ((w_state_nxt == S_RUN_UP) && w_fb99) begin
        w_state_nxt = S_RUN_DOWN;
        w_rev       = 1'b1;
      end else if ((w_state_nxt == S_RUN_DOWN) && w_fb00) begin
        w_state_nxt = S_RUN_UP;
        w_rev       = 1'b1;
      end
    end
  end

  // Prescaler phase is frozen while paused so a resume keeps the tick cadence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN_UP;
      r_saved_up <= 1'b1;
      r_presc    <= '0;
      r_mode     <= M_SWEEP;
      r_ud       <= 1'b1;
      r_pause    <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      if (r_state != S_PAUSED) begin
        r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
      end
      r_state    <= w_state_nxt;
      r_saved_up <= w_saved_nxt;
      r_mode     <= w_mode_nxt;
      r_ud       <= (w_state_nxt == S_RUN_UP) || ((w_state_nxt == S_PAUSED) && w_saved_nxt);
      r_pause    <= (w_state_nxt == S_PAUSED);
      r_wrap     <= w_rev;
    end
  end

  assign cnt_en = w_cnt_en;
  assign ud     = r_ud;
  assign pause  = r_pause;
  assign mode   = r_mode;
  assign wrap   = r_wrap | w_wrap_single;

endmodule

// File: tb/tb_bcd_sweep_ctrl.sv
// Bench for bcd_sweep_ctrl: directed and random button activity against a behavioural
// controller model plus a BCD counter model that closes the feedback loop.
module tb_bcd_sweep_ctrl;

  localparam int TICK = 4;
  localparam int DB   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_mode = 1'b0;
  logic [3:0] ten = 4'd0;
  logic [3:0] one = 4'd0;
  logic       cnt_en;
  logic       ud;
  logic       pause;
  logic [1:0] mode;
  logic       wrap;

  always #5 clk = ~clk;

  bcd_sweep_ctrl #(.TICK_DIV(TICK), .DEBOUNCE_CYC(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_mode(btn_mode),
    .ten(ten), .one(one), .cnt_en(cnt_en), .ud(ud), .pause(pause),
    .mode(mode), .wrap(wrap)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=up only, 1=down only, 2=sweep; running/paused flag plus
  // one direction bit (the running direction, or the remembered one while paused).
  int m_mode;
  bit m_paused;
  bit m_up;
  bit m_wrap_sw;
  int m_phase;
  int m_edge;
  bit m_lvl [2];
  bit m_pend0 [2];
  bit m_pend1 [2];
  bit m_hist [2][32];

  int cnt_v;
  bit bad_fb;
  bit last_en;
  bit last_ud;
  bit raw_p;
  bit raw_m;

  task automatic model_reset();
    m_mode = 2; m_paused = 0; m_up = 1; m_wrap_sw = 0; m_phase = 0; m_edge = 64;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 0; m_pend0[b] = 0; m_pend1[b] = 0;
      for (int i = 0; i < 32; i++) m_hist[b][i] = 0;
    end
    cnt_v = 0; last_en = 0; last_ud = 1;
  endtask

  task automatic drive_fb();
    if (!bad_fb) begin
      ten = 4'(cnt_v / 10);
      one = 4'(cnt_v % 10);
    end else begin
      case (cnt_v % 3)
        0: begin ten = 4'd9;  one = 4'hA; end
        1: begin ten = 4'hF;  one = 4'd9; end
        default: begin ten = 4'd0; one = 4'hE; end
      endcase
    end
  endtask

  // One active clock edge of the model; raw buttons are those driven for this edge.
  task automatic model_edge(input bit e_en, input bit f99, input bit f00);
    bit pr_p, pr_m, all_diff;
    pr_p = m_pend1[0];
    pr_m = m_pend1[1];
    m_hist[0][m_edge % 32] = raw_p;
    m_hist[1][m_edge % 32] = raw_m;
    for (int b = 0; b < 2; b++) begin
      // A button is seen two edges late through the synchronizer; it is accepted
      // once the last DB synchronized samples all disagree with the held level.
      all_diff = 1;
      for (int i = 0; i < DB; i++)
        if (m_hist[b][(m_edge - 2 - i) % 32] == m_lvl[b]) all_diff = 0;
      if (all_diff) m_lvl[b] = !m_lvl[b];
      m_pend1[b] = m_pend0[b];
      m_pend0[b] = all_diff && m_lvl[b];
    end
    m_edge++;

    if (!m_paused) m_phase = (m_phase + 1) % TICK;
    m_wrap_sw = 0;
    if (pr_m) begin
      m_mode = (m_mode == 2) ? 0 : m_mode + 1;
      if (!m_paused && m_mode == 0) m_up = 1;
      if (!m_paused && m_mode == 1) m_up = 0;
    end
    if (pr_p) begin
      if (m_paused) begin
        m_paused = 0;
        if (m_mode == 0) m_up = 1;
        if (m_mode == 1) m_up = 0;
      end else begin
        m_paused = 1;
      end
    end
    if (!m_paused && m_mode == 2 && !e_en) begin
      if (m_up && f99) begin m_up = 0; m_wrap_sw = 1; end
      else if (!m_up && f00) begin m_up = 1; m_wrap_sw = 1; end
    end
  endtask

  task automatic cycle();
    bit e_en, e_wrap, f99, f00;
    @(negedge clk);
    if (last_en) cnt_v = last_ud ? ((cnt_v == 99) ? 0 : cnt_v + 1)
                                 : ((cnt_v == 0) ? 99 : cnt_v - 1);
    drive_fb();
    btn_pause = raw_p;
    btn_mode  = raw_m;
    #1;
    f99    = (ten == 4'd9) && (one == 4'd9);
    f00    = (ten == 4'd0) && (one == 4'd0);
    e_en   = !m_paused && (m_phase == TICK - 1);
    e_wrap = m_wrap_sw || (e_en && ((m_mode == 0 && f99) || (m_mode == 1 && f00)));
    if (n_bad < 40) begin
      check_eq("cnt_en", {7'd0, cnt_en}, {7'd0, e_en});
      check_eq("ud",     {7'd0, ud},     {7'd0, m_up});
      check_eq("pause",  {7'd0, pause},  {7'd0, m_paused});
      check_eq("mode",   {6'd0, mode},   8'(m_mode));
      check_eq("wrap",   {7'd0, wrap},   {7'd0, e_wrap});
    end
    last_en = e_en;
    last_ud = m_up;
    model_edge(e_en, f99, f00);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input bit p, input bit m, input int gap);
    raw_p = p; raw_m = m;
    run(8);
    raw_p = 0; raw_m = 0;
    run(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cnt_en"}, {7'd0, cnt_en}, 8'd0);
    check_eq({tag, "_ud"},     {7'd0, ud},     8'd1);
    check_eq({tag, "_pause"},  {7'd0, pause},  8'd0);
    check_eq({tag, "_mode"},   {6'd0, mode},   8'd2);
    check_eq({tag, "_wrap"},   {7'd0, wrap},   8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem_p, rem_m;
    model_reset();
    raw_p = 0; raw_m = 0; bad_fb = 0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // Free-running sweep: up to 99, reverse, down to 00, reverse.
    run(1000);

    // Short bounce ignored, then pause / resume.
    raw_p = 1; run(2); raw_p = 0; run(20);
    press(1, 0, 40);
    press(1, 0, 40);

    // Up-only through 99, then down-only through 00.
    press(0, 1, 500);
    press(0, 1, 450);

    // Mode changes while paused, then resume; simultaneous presses while sweeping.
    press(1, 0, 20);
    press(0, 1, 20);
    press(0, 1, 20);
    press(0, 1, 20);
    press(1, 0, 30);
    press(0, 1, 30);
    press(1, 1, 30);
    press(1, 0, 200);

    // Out-of-range feedback digits are never terminal.
    bad_fb = 1; run(600);
    bad_fb = 0; run(50);

    // Random, partly bouncing button activity.
    rem_p = 0; rem_m = 0;
    repeat (6000) begin
      if (rem_p == 0) begin
        raw_p = !raw_p;
        rem_p = raw_p ? int'($urandom_range(1, 10)) : int'($urandom_range(4, 60));
      end
      if (rem_m == 0) begin
        raw_m = !raw_m;
        rem_m = raw_m ? int'($urandom_range(1, 10)) : int'($urandom_range(4, 90));
      end
      rem_p--; rem_m--;
      cycle();
    end
    raw_p = 0; raw_m = 0;
    run(30);

    // Move away from reset values, then reset asynchronously with a press pending.
    for (int k = 0; k < 3; k++) if (m_mode != 0) press(0, 1, 20);
    if (!m_paused) press(1, 0, 20);
    raw_p = 1; raw_m = 1;
    run(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    raw_p = 0; raw_m = 0;
    btn_pause = 1'b0; btn_mode = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    run(120);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
